vec_regfile_scoreboard: RTL

//  Next-generation decode-stage register file: VEC_SIZE-lane vector bank plus scalar bank, selected by the MSB
//  of each register select (1 = scalar, broadcast to all lanes). Adds per-lane masked writeback, same-cycle

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/regfile_scoreboard.sv | 76 +++++++
 rtl/vec_regfile_scoreboard.sv | 97 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared configuration, types and select-decoding helpers for the vector/scalar register file.
package regfile_pkg;

    localparam int REG_SIZE = 8;
    localparam int SEL_BITS = 3;
    localparam int VEC_SIZE = 4;
    localparam int ZERO_REG = 1;
    localparam int REG_QTY  = 2 ** SEL_BITS;
    localparam int CNT_W    = $clog2(2 * REG_QTY + 1);

    localparam logic SCALAR_BANK = 1'b1;

    typedef logic [REG_SIZE-1:0]                lane_t;
    typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0]  vec_t;
    typedef logic [SEL_BITS:0]                  sel_t;

    // MSB of a select chooses the scalar bank
    function automatic logic is_scalar(input sel_t sel);
        return (sel[SEL_BITS] == SCALAR_BANK);
    endfunction

    // Index of the register within its bank
    function automatic logic [SEL_BITS-1:0] bank_idx(input sel_t sel);
        return sel[SEL_BITS-1:0];
    endfunction

    // Index 0 of either bank is the hardwired zero register when enabled
    function automatic logic is_zero_reg(input sel_t sel);
        return (ZERO_REG != 0) && (bank_idx(sel) == {SEL_BITS{1'b0}});
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register of both banks, RAW/WAW stall and popcount.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  sel_t             rd_sel1,
    input  sel_t             rd_sel2,
    input  logic             issue_valid,
    input  sel_t             issue_dst,
    input  logic             wb_valid,
    input  sel_t             wb_dst,
    output logic             stall,
    output logic [CNT_W-1:0] pending_cnt
);

    logic [2*REG_QTY-1:0] r_pending;
    logic [2*REG_QTY-1:0] w_pending_nxt;
    logic [2*REG_QTY-1:0] w_busy;
    logic                 w_stall;
    logic                 w_accept;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [CNT_W-1:0]     r_cnt;

    // A register is busy while pending, unless its writeback lands this very cycle
    always_comb begin
        w_busy = '0;
        for (int s = 0; s < 2 * REG_QTY; s++) begin
            w_busy[s] = r_pending[s] && !(wb_valid && (wb_dst == sel_t'(s)));
        end
    end

    // Stall on any hazard touching the sources or the destination
    always_comb begin
        w_stall  = issue_valid && (w_busy[rd_sel1] || w_busy[rd_sel2] || w_busy[issue_dst]);
        w_accept = issue_valid && !w_stall;
    end

    // Next pending state: writeback clears first, accepted issue sets afterwards so set wins
    always_comb begin
        w_pending_nxt = r_pending;
        if (wb_valid) begin
            w_pending_nxt[wb_dst] = 1'b0;
        end else begin
            w_pending_nxt[wb_dst] = r_pending[wb_dst];
        end
        if (w_accept && !is_zero_reg(issue_dst)) begin
            w_pending_nxt[issue_dst] = 1'b1;
        end else begin
            w_pending_nxt[issue_dst] = w_pending_nxt[issue_dst];
        end
    end

    // Popcount of the next pending state so the registered count tracks the pending bits
    always_comb begin
        w_cnt_nxt = '0;
        for (int s = 0; s < 2 * REG_QTY; s++) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_pending_nxt[s]);
        end
    end

    // Pending bits and their count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign stall       = w_stall;
    assign pending_cnt = r_cnt;

endmodule

// File: rtl/vec_regfile_scoreboard.sv
// Decode-stage register file: vector and scalar banks, masked writeback, write-to-read bypass,
// scalar broadcast, hardwired zero register and a pending-write scoreboard.
module vec_regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SEL_BITS:0]            rd_sel1,
    input  logic [SEL_BITS:0]            rd_sel2,
    output logic [VEC_SIZE*REG_SIZE-1:0] operand1,
    output logic [VEC_SIZE*REG_SIZE-1:0] operand2,
    input  logic                         issue_valid,
    input  logic [SEL_BITS:0]            issue_dst,
    output logic                         stall,
    input  logic                         wb_valid,
    input  logic [SEL_BITS:0]            wb_dst,
    input  logic [VEC_SIZE-1:0]          wb_mask,
    input  logic [VEC_SIZE*REG_SIZE-1:0] wb_data,
    output logic [CNT_W-1:0]             pending_cnt
);

    vec_t  r_vbank [REG_QTY];
    lane_t r_sbank [REG_QTY];
    vec_t  w_wb_data;

    assign w_wb_data = wb_data;

    // Masked writeback into the selected bank; zero register writes are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_QTY; i++) begin
                r_vbank[i] <= '0;
                r_sbank[i] <= '0;
            end
        end else if (wb_valid && !is_zero_reg(wb_dst)) begin
            if (is_scalar(wb_dst)) begin
                if (wb_mask[0]) begin
                    r_sbank[bank_idx(wb_dst)] <= w_wb_data[0];
                end
            end else begin
                for (int l = 0; l < VEC_SIZE; l++) begin
                    if (wb_mask[l]) begin
                        r_vbank[bank_idx(wb_dst)][l] <= w_wb_data[l];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        sel_t w_sel;
        logic w_byp;
        vec_t w_val;

        assign w_sel = (p == 0) ? rd_sel1 : rd_sel2;

        // Read mux: zero gating, bank select, per-lane bypass and scalar broadcast
        always_comb begin
            w_byp = wb_valid && (wb_dst == w_sel);
            w_val = '0;
            if (is_zero_reg(w_sel)) begin
                w_val = '0;
            end else if (is_scalar(w_sel)) begin
                if (w_byp && wb_mask[0]) begin
                    w_val = {VEC_SIZE{w_wb_data[0]}};
                end else begin
                    w_val = {VEC_SIZE{r_sbank[bank_idx(w_sel)]}};
                end
            end else begin
                for (int l = 0; l < VEC_SIZE; l++) begin
                    if (w_byp && wb_mask[l]) begin
                        w_val[l] = w_wb_data[l];
                    end else begin
                        w_val[l] = r_vbank[bank_idx(w_sel)][l];
                    end
                end
            end
        end
    end

    assign operand1 = g_rd[0].w_val;
    assign operand2 = g_rd[1].w_val;

    regfile_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .rd_sel1     (rd_sel1),
        .rd_sel2     (rd_sel2),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .wb_valid    (wb_valid),
        .wb_dst      (wb_dst),
        .stall       (stall),
        .pending_cnt (pending_cnt)
    );

endmodule
